// File: rtl/proc_elem.sv
// Convolution processing element: KxK window times KxK kernel, summed through a
// pipelined binary adder tree. One window per clock, fixed latency of 1 + clog2(K*K).
module proc_elem #(
   parameter int KERNEL_SIZE = 3,
   parameter int PX_SIZE = 8,
   localparam int NUM_INPUTS = KERNEL_SIZE * KERNEL_SIZE,
   localparam int ADDER_IN_SIZE = 2 * PX_SIZE,
   localparam int TREE_LEVELS = $clog2(NUM_INPUTS),
   localparam int ADDER_OUT_SIZE = ADDER_IN_SIZE + TREE_LEVELS,
   localparam int LATENCY = 1 + TREE_LEVELS
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               in_valid,
   input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] img_in,
   input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] kernel_in,
   output logic                                               out_valid,
   output logic [ADDER_OUT_SIZE-1:0]                          img_out
);

   // Valid-only streaming: a window is accepted on every edge where in_valid=1 and
   // its sum appears with out_valid=1 exactly LATENCY edges later; no ready/stall.
   logic [LATENCY-1:0] vld;

   always_ff @(posedge clk) begin
      if (rst) vld <= '0;
      else     vld <= (vld << 1) | LATENCY'(in_valid);
   end

   assign out_valid = vld[LATENCY-1];

   // Level 0 holds the products; each later level halves the operand count
   // (rounding up) and grows one bit. Flat operand index i maps to [i/K][i%K].
   for (genvar l = 0; l <= TREE_LEVELS; l++) begin : g_lvl
      localparam int W   = ADDER_IN_SIZE + l;
      localparam int CNT = (NUM_INPUTS + (1 << l) - 1) >> l;
      for (genvar i = 0; i < CNT; i++) begin : g_node
         logic [W-1:0] q;
         if (l == 0) begin : g_mul
            always_ff @(posedge clk) begin
               if (rst) q <= '0;
               else     q <= W'(img_in[i / KERNEL_SIZE][i % KERNEL_SIZE]) *
                             W'(kernel_in[i / KERNEL_SIZE][i % KERNEL_SIZE]);
            end
         end else begin : g_add
            localparam int PCNT = (NUM_INPUTS + (1 << (l - 1)) - 1) >> (l - 1);
            if (2 * i + 1 < PCNT) begin : g_pair
               always_ff @(posedge clk) begin
                  if (rst) q <= '0;
                  else     q <= W'(g_lvl[l-1].g_node[2*i].q) + W'(g_lvl[l-1].g_node[2*i+1].q);
               end
            end else begin : g_pass
               // Odd leftover operand rides through unchanged to keep levels aligned.
               always_ff @(posedge clk) begin
                  if (rst) q <= '0;
                  else     q <= W'(g_lvl[l-1].g_node[2*i].q);
               end
            end
         end
      end
   end

   assign img_out = ADDER_OUT_SIZE'(g_lvl[TREE_LEVELS].g_node[0].q);

endmodule

// File: tb/tb_proc_elem.sv
// Directed bench for proc_elem (K=3, PX=8): driver pushes hand-computed sums with
// their due cycle into a scoreboard; a monitor compares whenever a result is due or shown.
module tb_proc_elem;
   localparam int K   = 3;
   localparam int PX  = 8;
   localparam int OW  = 20;
   localparam int LAT = 5;

   typedef logic [K-1:0][K-1:0][PX-1:0] win_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   win_t          img_in = '0;
   win_t          kernel_in = '0;
   logic          out_valid;
   logic [OW-1:0] img_out;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_pass = 0;
   logic [OW-1:0] exp_q[$];
   int            due_q[$];

   proc_elem #(.KERNEL_SIZE(K), .PX_SIZE(PX)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .img_in(img_in),
      .kernel_in(kernel_in), .out_valid(out_valid), .img_out(img_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic win_t fill(input int v);
      win_t w;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) w[r][c] = PX'(v);
      return w;
   endfunction

   function automatic win_t seq();
      win_t w;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) w[r][c] = PX'(r * K + c + 1);
      return w;
   endfunction

   function automatic win_t one_at(input int r, input int c, input int v);
      win_t w = '0;
      w[r][c] = PX'(v);
      return w;
   endfunction

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive(input win_t img, input win_t ker, input int exp);
      @(negedge clk);
      img_in = img;
      kernel_in = ker;
      in_valid = 1'b1;
      exp_q.push_back(OW'(exp));
      due_q.push_back(cyc + LAT);
   endtask

   task automatic bubble();
      @(negedge clk);
      img_in = win_t'({$urandom, $urandom, $urandom});
      kernel_in = win_t'({$urandom, $urandom, $urandom});
      in_valid = 1'b0;
   endtask

   // Monitor: a result due this cycle must be present; any other out_valid is stray.
   initial begin
      forever begin
         @(negedge clk);
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            if (!out_valid) begin
               n_checks++;
               $display("FAIL missing_out: out_valid=0 at cycle %0d expected sum %0d", cyc, exp_q[0]);
            end else begin
               check("sum", img_out, exp_q[0]);
            end
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
         end else if (out_valid) begin
            n_checks++;
            $display("FAIL stray_out: out_valid=1 img_out=%0d at cycle %0d, expected none", img_out, cyc);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_valid", OW'(out_valid), '0);
      check("reset_out", img_out, '0);
      rst = 1'b0;

      drive(fill(0), fill(0), 0);
      drive(fill(1), fill(1), 9);
      drive(fill(255), fill(255), 585225);
      drive(seq(), one_at(1, 1, 1), 5);
      drive(seq(), one_at(2, 2, 1), 9);
      drive(seq(), one_at(0, 0, 1), 1);
      drive(seq(), one_at(0, 2, 2), 6);
      drive(seq(), seq(), 285);
      bubble();
      drive(fill(2), fill(1), 18);
      drive(fill(3), fill(1), 27);
      bubble();
      drive(fill(4), fill(1), 36);
      bubble();
      repeat (LAT + 2) @(negedge clk);

      // Reset two cycles after a launch: the in-flight window must vanish.
      drive(fill(5), fill(1), 45);
      bubble();
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      due_q.delete();
      @(negedge clk);
      check("rst_mid_valid", OW'(out_valid), '0);
      check("rst_mid_out", img_out, '0);
      rst = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
